uart_tx_serializer: RTL

UART transmit serializer that sits directly downstream of the baud-rate generator. It accepts a parallel byte over a valid/ready handshake and shifts out one asynchronous serial frame: start bit, data bits LSB-first, optional parity bit, and 1 or 2 stop bits. It enables the baud generator for the duration of each frame and advances one bit per generator bit-done pulse. The serial line idles high.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx_serializer.sv | 109 ++++++++++
 2 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity-mode encodings and the parity helper.
// The receiver reuses this package, so nothing here is specific to the transmitter.
package uart_pkg;

  localparam int MAX_DATA_BITS = 9;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  // Narrower words are zero-extended into data; extra zeros leave the XOR unchanged.
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    case (mode)
      PARITY_ODD:  return ~^data;
      PARITY_EVEN: return ^data;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: accepts a word over valid/ready and shifts out
// start, LSB-first data, optional parity and stop bits, one bit per bit_tick.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PARITY_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 baud_en,
  input  logic                 bit_tick,
  output logic                 tx,
  output logic                 tx_done,
  output logic                 busy
);

  localparam int               CNT_W     = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 stop_cnt;

  assign tx_ready = (state == ST_IDLE);
  assign busy     = ~tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx       <= 1'b1;
      baud_en  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // bit_tick is deliberately not looked at here, even on the accept edge.
          if (tx_valid) begin
            shreg   <= tx_data;
            par_bit <= calc_parity(MAX_DATA_BITS'(tx_data), PARITY);
            tx      <= 1'b0;
            baud_en <= 1'b1;
            state   <= ST_START;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt != LAST_BIT) begin
              // The bit after the shift is shreg[1] now, so drive it directly.
              bit_cnt <= bit_cnt + CNT_W'(1);
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end else if (PARITY != PARITY_NONE) begin
              tx    <= par_bit;
              state <= ST_PARITY;
            end else begin
              stop_cnt <= 1'b0;
              tx       <= 1'b1;
              state    <= ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            state    <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (bit_tick) begin
            if (stop_cnt != LAST_STOP) begin
              stop_cnt <= 1'b1;
            end else begin
              baud_en <= 1'b0;
              tx_done <= 1'b1;
              state   <= ST_IDLE;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          baud_en <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
